// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync + deglitch, 11-bit framing, stop check, stall watchdog.
// Optional odd-parity enforcement is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic                  ps2c_s;
    logic                  ps2d_s;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  filt_clk;
    logic                  filt_clk_d;
    logic                  fall_edge_c;

    state_t            state_q, state_d;
    frame_t            shift_q, shift_d;
    frame_t            shift_in_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic              perr_q, perr_d;
`endif

    assign ps2c_s = c_sync[1];
    assign ps2d_s = d_sync[1];

    // Two-flop synchronisers, idle-high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // Glitch filter: level changes only after FILTER_LEN agreeing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q     <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_q     <= {filt_q[FILTER_LEN-2:0], ps2c_s};
            filt_clk_d <= filt_clk;
            if (&filt_q) begin
                filt_clk <= 1'b1;
            end else if (~|filt_q) begin
                filt_clk <= 1'b0;
            end
        end
    end

    assign fall_edge_c = filt_clk_d & ~filt_clk;
    assign shift_in_c  = frame_t'({ps2d_s, shift_q[9:1]});

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Strobes are computed on the transition into LOAD so they are high during LOAD itself
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall_edge_c && rx_en && !ps2d_s) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(9);
                    wd_d    = '0;
                end
            end
            SHIFT: begin
                if (fall_edge_c) begin
                    shift_d = shift_in_c;
                    wd_d    = '0;
                    if (cnt_q == '0) begin
                        state_d = LOAD;
                        if (!shift_in_c.stop) begin
                            ferr_d = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
                        end else if (!(^{shift_in_c.parity, shift_in_c.data})) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            done_d = 1'b1;
                            dout_d = shift_in_c.data;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (wd_q == WD_LAST) begin
                    // Stalled frame: drop it so the next start bit is framed correctly
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;
`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
PS/2 device-to-host serial receiver feeding the keyboard scan-code decoder. Synchronises and deglitches ps2c/ps2d, frames 11-bit PS/2 packets (start, 8 data LSB-first, odd parity, stop) and presents each byte with a one-cycle done strobe. Adds stop-bit validation and a stalled-frame watchdog so a dropped clock edge cannot desynchronise every following scan code.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised ps2c samples needed to change the filtered clock level (2..16)
TIMEOUT_CYCLES, 200000, clk cycles without a filtered falling edge mid-frame before abort (2 ms at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
ps2d  input  1  raw PS/2 data line
ps2c  input  1  raw PS/2 clock line
rx_en  input  1  receive enable; gates frame start only
rx_done_tick  output  1  one-cycle strobe: valid byte on dout
dout  output  8  last received byte; holds until next rx_done_tick
frame_err  output  1  one-cycle strobe: bad stop bit or watchdog abort
parity_err  output  1  one-cycle strobe: parity failure (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rx_done_tick=0, frame_err=0, parity_err=0, dout=8'h00, shift reg=0, bit counter=0, watchdog=0, filter shift reg all ones, filtered clock=1, synchronisers=1.
- Input path: ps2c and ps2d each pass through a 2-flop synchroniser. Synchronised ps2c shifts into a FILTER_LEN-bit register; filtered clock goes to 1 when all bits are 1, to 0 when all bits are 0, otherwise holds. fall_edge = filtered clock 1 in the previous cycle and 0 now, one-cycle pulse.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE: on fall_edge & rx_en & synchronised ps2d==0 (start bit) -> SHIFT, counter=9, watchdog=0. fall_edge with ps2d==1 is ignored and the FSM stays in IDLE.
- SHIFT: each fall_edge shifts the synchronised ps2d into bit 9 of a 10-bit register, shifting right, and restarts the watchdog. After 10 bits the register holds {stop, parity, d7..d0}. When fall_edge arrives with counter==0 -> LOAD; otherwise decrement. rx_en deassertion in SHIFT has no effect; the frame completes.
- Watchdog: in SHIFT, counts clk cycles since the last fall_edge. On reaching TIMEOUT_CYCLES-1 -> IDLE and frame_err pulses for 1 cycle. No rx_done_tick; dout is unchanged.
- LOAD (1 cycle, then IDLE): if stop==1 and parity is accepted, rx_done_tick=1 and dout=d7..d0, both visible in the LOAD cycle, which is 1 clk after the stop-bit fall_edge. If stop==0, frame_err=1 and dout is held.
- Parity is odd: accepted iff XOR of {parity, d7..d0} == 1.
- All strobes are Moore outputs of the registered state and are high for exactly 1 cycle. rx_done_tick and frame_err are never high together.
- Back-to-back frames: IDLE accepts a start edge on the cycle immediately after LOAD.
- End-to-end latency from raw stop-bit falling edge to rx_done_tick = 2 (sync) + FILTER_LEN + 2 clk (±1).

Optional Feature:
PS2_RX_PARITY_CHECK_EN
- Defined: a parity failure with a valid stop bit pulses parity_err for 1 cycle in LOAD, suppresses rx_done_tick and leaves dout unchanged. A frame with both a bad stop bit and bad parity pulses frame_err only.
- Undefined: the parity bit is shifted but ignored, parity_err is tied to 0, and any frame with stop==1 produces rx_done_tick.

Test Plan:
- Good frame 0x29 (bits 0,1,0,0,1,0,1,0,0,p=0,1) at a 12.5 kHz PS/2 clock, rx_en=1 -> one rx_done_tick, dout=8'h29, frame_err=0.
- Frames 0xF0 then 0x29 back-to-back (one PS/2 bit-time gap) -> two ticks, dout sequence F0 then 29, no errors.
- Frame 0x5A with stop bit 0 -> frame_err one cycle, no tick, dout keeps its previous value (8'h29).
- Start bit plus 4 data bits, then ps2c held high for TIMEOUT_CYCLES -> frame_err after TIMEOUT_CYCLES; a following good 0x5A frame -> tick, dout=8'h5A.
- With the macro defined: 0x29 sent with p=1 -> parity_err pulse, no tick. Without the macro, the same frame -> tick, dout=8'h29, parity_err stays 0.
- ps2c glitches low for FILTER_LEN-1 cycles in IDLE, and rx_en=0 during a start bit -> no state change and no strobes. Asserting reset low mid-frame -> all outputs return to reset values immediately, and the next clean frame is received correctly.
